// File: rtl/sort_three_floats_fsm.sv
// Sequential ascending sorter for three IEEE-754 doubles: one shared magnitude
// comparator applied over three compare-and-swap states, result flagged by a one-cycle pulse.
module sort_three_floats_fsm #(
  parameter int unsigned FLEN = 64,
  parameter int unsigned NE   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  input  logic [0:2][FLEN-1:0] unsorted,
  output logic                 up_ready,
  output logic                 down_valid,
  output logic [0:2][FLEN-1:0] sorted,
  output logic                 err
);

  typedef enum logic [2:0] {StIdle, StCmp01, StCmp12, StCmp01b, StDone} state_e;

  state_e          state_q, state_d;
  logic [FLEN-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
  logic            err_q, err_d;
  logic            in_err;
  logic [FLEN-1:0] cmp_a, cmp_b;
  logic            cmp_gt;

  // Sign-magnitude ordering without arithmetic; +0 and -0 compare equal.
  function automatic logic gt(input logic [FLEN-1:0] a, input logic [FLEN-1:0] b);
    logic [FLEN-2:0] ma, mb;
    ma = a[FLEN-2:0];
    mb = b[FLEN-2:0];
    if (ma == '0 && mb == '0) return 1'b0;
    else if (a[FLEN-1] != b[FLEN-1]) return ~a[FLEN-1];
    else if (!a[FLEN-1]) return ma > mb;
    else return ma < mb;
  endfunction

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_err = in_err | (&unsorted[i][FLEN-2 -: NE]);
    end
  end

  // The single comparator sees (r1,r2) in CMP12 and (r0,r1) otherwise.
  always_comb begin
    cmp_a = r0_q;
    cmp_b = r1_q;
    if (state_q == StCmp12) begin
      cmp_a = r1_q;
      cmp_b = r2_q;
    end
  end

  assign cmp_gt = gt(cmp_a, cmp_b);

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (up_valid) begin
          r0_d    = unsorted[0];
          r1_d    = unsorted[1];
          r2_d    = unsorted[2];
          err_d   = in_err;
          state_d = in_err ? StDone : StCmp01;
        end
      end
      StCmp01: begin
        if (cmp_gt) begin
          r0_d = r1_q;
          r1_d = r0_q;
        end
        state_d = StCmp12;
      end
      StCmp12: begin
        if (cmp_gt) begin
          r1_d = r2_q;
          r2_d = r1_q;
        end
        state_d = StCmp01b;
      end
      StCmp01b: begin
        if (cmp_gt) begin
          r0_d = r1_q;
          r1_d = r0_q;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      err_q   <= err_d;
    end
  end

  assign up_ready   = (state_q == StIdle);
  assign down_valid = (state_q == StDone);
  assign sorted     = {r0_q, r1_q, r2_q};
  assign err        = err_q;

endmodule
